// File: rtl/decoder_pipe_n.sv
// Registered N-to-2^N decoder with one-hot, thermometer and walking-one scan modes.
// A single output register stage sits between valid/ready handshakes on both sides.
module decoder_pipe_n #(
   parameter int IN_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_W-1:0]        in,
   input  logic [1:0]             mode,
   input  logic                   enable,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [(2**IN_W)-1:0]   out,
   output logic                   busy
);

   localparam int OUT_W = 2**IN_W;

   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

   state_t           state;
   state_t           state_next;
   logic [OUT_W-1:0] out_reg;
   logic [OUT_W-1:0] decoded;
   logic [IN_W-1:0]  idx;
   logic             accept;
   logic             scan_last;
   logic             start_scan;

   assign accept     = in_valid && in_ready;
   assign scan_last  = (idx == '1);
   // A scan starting at the top bit is a single beat, so it is treated as a plain hold.
   assign start_scan = (mode == 2'b10) && enable && (in != '1);
   assign out        = out_reg;

   always_comb begin
      decoded = '0;
      if (enable) begin
         for (int i = 0; i < OUT_W; i++) begin
            case (mode)
               2'b00, 2'b10: decoded[i] = (i == int'(in));
               2'b01:        decoded[i] = (i <= int'(in));
               default:      decoded[i] = 1'b0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = start_scan ? SCAN : HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               if (accept) state_next = start_scan ? SCAN : HOLD;
               else        state_next = IDLE;
            end
         end
         SCAN: begin
            if (out_ready && scan_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         SCAN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // The word register changes only on accept or when downstream takes the current beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg <= '0;
         idx     <= '0;
      end else if (accept) begin
         out_reg <= decoded;
         idx     <= in;
      end else if (state == SCAN && out_ready) begin
         out_reg <= scan_last ? '0 : (out_reg << 1);
         idx     <= idx + IN_W'(1);
      end else if (state == HOLD && out_ready) begin
         out_reg <= '0;
      end
   end

endmodule

// File: tb/tb_decoder_pipe_n.sv
// Directed self-checking bench for decoder_pipe_n: a 5-bit instance for most
// scenarios and a 3-bit instance for the narrow scan case.
module tb_decoder_pipe_n;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  mode;
   logic        enable;
   logic        out_ready;
   logic [4:0]  in_b;
   logic        in_ready_b, out_valid_b, busy_b;
   logic [31:0] out_b;
   logic [2:0]  in_s;
   logic        in_ready_s, out_valid_s, busy_s;
   logic [7:0]  out_s;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   decoder_pipe_n #(.IN_W(5)) dut_big (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in(in_b),
      .mode(mode), .enable(enable), .out_valid(out_valid_b), .out_ready(out_ready),
      .out(out_b), .busy(busy_b)
   );

   decoder_pipe_n #(.IN_W(3)) dut_small (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in(in_s),
      .mode(mode), .enable(enable), .out_valid(out_valid_s), .out_ready(out_ready),
      .out(out_s), .busy(busy_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_b = '0; in_s = '0; mode = 2'b00; enable = 1'b1; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      total++; if (out_b !== 32'h0)  $display("FAIL reset_out got=%h exp=%h", out_b, 32'h0); else passed++;
      total++; if (out_valid_b !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid_b); else passed++;
      total++; if (busy_b !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_b); else passed++;
      total++; if (in_ready_b !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready_b); else passed++;
   endtask

   task automatic test_onehot();
      in_valid = 1'b1; in_b = 5'd7; mode = 2'b00; enable = 1'b1; out_ready = 1'b1;
      tick();
      total++; if (out_b !== 32'h00000080) $display("FAIL onehot7 got=%h exp=%h", out_b, 32'h00000080); else passed++;
      total++; if (out_valid_b !== 1'b1) $display("FAIL onehot7_valid got=%b exp=1", out_valid_b); else passed++;
      in_b = 5'd31;
      tick();
      total++; if (out_b !== 32'h80000000) $display("FAIL onehot31 got=%h exp=%h", out_b, 32'h80000000); else passed++;
      in_valid = 1'b0;
      tick();
      total++; if (out_valid_b !== 1'b0) $display("FAIL onehot_drain_valid got=%b exp=0", out_valid_b); else passed++;
   endtask

   task automatic test_thermometer();
      logic [4:0]  vin  [4] = '{5'd3, 5'd31, 5'd0, 5'd0};
      logic        ven  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] vexp [4] = '{32'h0000000F, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      mode = 2'b01; out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_b = vin[i]; enable = ven[i];
         tick();
         total++; if (out_b !== vexp[i]) $display("FAIL thermo_%0d got=%h exp=%h", i, out_b, vexp[i]); else passed++;
         total++; if (out_valid_b !== 1'b1) $display("FAIL thermo_valid_%0d got=%b exp=1", i, out_valid_b); else passed++;
      end
      in_valid = 1'b0; enable = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      logic        rdy  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic        vld  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [4:0]  din  [7] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd3, 5'd0, 5'd0};
      logic        eir  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic        eval [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] eout [7] = '{32'h0, 32'h1, 32'h2, 32'h2, 32'h4, 32'h8, 32'h8};
      logic [31:0] expected_words [4] = '{32'h1, 32'h2, 32'h4, 32'h8};
      logic [31:0] got [$];
      mode = 2'b00; enable = 1'b1;
      for (int c = 0; c < 7; c++) begin
         out_ready = rdy[c]; in_valid = vld[c]; in_b = din[c];
         #1;
         total++; if (in_ready_b !== eir[c]) $display("FAIL b2b_in_ready_c%0d got=%b exp=%b", c, in_ready_b, eir[c]); else passed++;
         total++; if (out_valid_b !== eval[c]) $display("FAIL b2b_valid_c%0d got=%b exp=%b", c, out_valid_b, eval[c]); else passed++;
         if (eval[c]) begin
            total++; if (out_b !== eout[c]) $display("FAIL b2b_out_c%0d got=%h exp=%h", c, out_b, eout[c]); else passed++;
         end
         if (out_valid_b && out_ready) got.push_back(out_b);
         tick();
      end
      total++; if (got.size() !== 4) $display("FAIL b2b_count got=%0d exp=4", got.size()); else passed++;
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         total++; if (got[i] !== expected_words[i]) $display("FAIL b2b_word%0d got=%h exp=%h", i, got[i], expected_words[i]); else passed++;
      end
      total++; if (out_valid_b !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", out_valid_b); else passed++;
   endtask

   task automatic test_scan();
      logic [31:0] beats [3] = '{32'h20000000, 32'h40000000, 32'h80000000};
      in_valid = 1'b1; in_b = 5'd29; mode = 2'b10; enable = 1'b1; out_ready = 1'b0;
      tick();
      in_b = 5'd3;
      for (int s = 0; s < 3; s++) begin
         #1;
         total++; if (out_b !== beats[0]) $display("FAIL scan_stall%0d got=%h exp=%h", s, out_b, beats[0]); else passed++;
         total++; if (busy_b !== 1'b1 || in_ready_b !== 1'b0) $display("FAIL scan_stall_flags%0d got busy=%b in_ready=%b exp busy=1 in_ready=0", s, busy_b, in_ready_b); else passed++;
         tick();
      end
      out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         #1;
         total++; if (out_b !== beats[b]) $display("FAIL scan_beat%0d got=%h exp=%h", b, out_b, beats[b]); else passed++;
         total++; if (busy_b !== 1'b1 || in_ready_b !== 1'b0 || out_valid_b !== 1'b1) $display("FAIL scan_flags%0d got busy=%b in_ready=%b valid=%b exp 1/0/1", b, busy_b, in_ready_b, out_valid_b); else passed++;
         tick();
      end
      in_valid = 1'b0;
      #1;
      total++; if (busy_b !== 1'b0 || out_valid_b !== 1'b0 || in_ready_b !== 1'b1) $display("FAIL scan_end got busy=%b valid=%b in_ready=%b exp 0/0/1", busy_b, out_valid_b, in_ready_b); else passed++;
      in_valid = 1'b1; in_b = 5'd31;
      tick();
      in_valid = 1'b0;
      total++; if (out_b !== 32'h80000000 || busy_b !== 1'b0) $display("FAIL scan_top got out=%h busy=%b exp out=80000000 busy=0", out_b, busy_b); else passed++;
      tick();
      total++; if (out_valid_b !== 1'b0) $display("FAIL scan_top_drain got=%b exp=0", out_valid_b); else passed++;
   endtask

   task automatic test_reset_mid_scan();
      in_valid = 1'b1; in_b = 5'd0; mode = 2'b10; enable = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      total++; if (out_b !== 32'h00000010) $display("FAIL midscan_beat got=%h exp=%h", out_b, 32'h00000010); else passed++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (out_b !== 32'h0 || out_valid_b !== 1'b0 || busy_b !== 1'b0) $display("FAIL midscan_reset got out=%h valid=%b busy=%b exp 0/0/0", out_b, out_valid_b, busy_b); else passed++;
      total++; if (in_ready_b !== 1'b1) $display("FAIL midscan_idle got=%b exp=1", in_ready_b); else passed++;
      in_valid = 1'b1; in_b = 5'd2; mode = 2'b00;
      tick();
      in_valid = 1'b0;
      total++; if (out_b !== 32'h00000004) $display("FAIL midscan_after got=%h exp=%h", out_b, 32'h00000004); else passed++;
      tick();
   endtask

   task automatic test_reserved();
      in_valid = 1'b1; in_b = 5'd5; mode = 2'b11; enable = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      total++; if (out_b !== 32'h0 || out_valid_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL reserved got out=%h valid=%b busy=%b exp 0/1/0", out_b, out_valid_b, busy_b); else passed++;
      tick();
      total++; if (out_valid_b !== 1'b0) $display("FAIL reserved_drain got=%b exp=0", out_valid_b); else passed++;
   endtask

   task automatic test_small_scan();
      logic [7:0] beats [3] = '{8'h20, 8'h40, 8'h80};
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      in_valid = 1'b1; in_s = 3'd5; mode = 2'b10; enable = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         total++; if (out_s !== beats[b] || busy_s !== 1'b1) $display("FAIL small_beat%0d got out=%h busy=%b exp out=%h busy=1", b, out_s, busy_s, beats[b]); else passed++;
         tick();
      end
      total++; if (out_valid_s !== 1'b0 || busy_s !== 1'b0) $display("FAIL small_idle got valid=%b busy=%b exp 0/0", out_valid_s, busy_s); else passed++;
   endtask

   initial begin
      test_reset();
      test_onehot();
      test_thermometer();
      test_back_to_back();
      test_scan();
      test_reset_mid_scan();
      test_reserved();
      test_small_scan();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
